// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and response signals of the ALU command sequencer.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned ADR_W = 2;
    localparam int unsigned FLG_W = 3;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_load;
    logic [OP_W-1:0]    cmd_op;
    logic [ADR_W-1:0]   cmd_rd;
    logic [ADR_W-1:0]   cmd_rs1;
    logic [ADR_W-1:0]   cmd_rs2;
    logic [WIDTH-1:0]   cmd_imm;

    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [OP_W-1:0]    alu_op;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_cout;
    logic               alu_c_flag;
    logic               alu_zero;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic [FLG_W-1:0]   rsp_flags;

    logic               busy;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  alu_out, alu_cout, alu_c_flag, alu_zero,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_flags, busy
    );

    // Instruction source, ALU and response consumer side
    modport slave (
        output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output alu_out, alu_cout, alu_c_flag, alu_zero,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_flags, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: owns a 4-entry register file, drives a combinational
// ALU for one cycle per command and returns the written value on a
// valid/ready response channel. One command in flight at a time.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.master  bus
);
    localparam int unsigned OP_W  = 3;
    localparam int unsigned ADR_W = 2;
    localparam int unsigned FLG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   regs_q [NREG];
    logic [WIDTH-1:0]   regs_d [NREG];
    logic [WIDTH-1:0]   alu_a_q,     alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,     alu_b_d;
    logic [OP_W-1:0]    alu_op_q,    alu_op_d;
    logic [ADR_W-1:0]   rd_q,        rd_d;
    logic [WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic [FLG_W-1:0]   rsp_flags_q, rsp_flags_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q,      busy_d;

    // State register and datapath flops; reset abandons any command in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, register-file writeback and ALU operand selection
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_load) begin
                        regs_d[bus.cmd_rd] = bus.cmd_imm;
                        rsp_data_d         = bus.cmd_imm;
                        rsp_flags_d        = {2'b00, bus.cmd_imm == WIDTH'(0)};
                        state_d            = RESP;
                    end else begin
                        // Operands come from pre-edge contents, so rd==rs is safe
                        alu_a_d  = regs_q[bus.cmd_rs1];
                        alu_b_d  = regs_q[bus.cmd_rs2];
                        alu_op_d = bus.cmd_op;
                        rd_d     = bus.cmd_rd;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                regs_d[rd_q] = bus.alu_out;
                rsp_data_d   = bus.alu_out;
                rsp_flags_d  = {bus.alu_cout, bus.alu_c_flag, bus.alu_zero};
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies decoded from the next state
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a reference ALU attached.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst_n;

    alu_cmd_sequencer_if #(.WIDTH(8)) bus ();

    alu_cmd_sequencer #(.WIDTH(8), .NREG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference 8-bit ALU: carry out of add, no-borrow carry of subtract
    logic [8:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            3'b000: alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b001: alu_res = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
            3'b010: alu_res = {1'b0, bus.alu_a & bus.alu_b};
            3'b011: alu_res = {1'b0, bus.alu_a | bus.alu_b};
            3'b100: alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
            3'b101: alu_res = {8'd0, bus.alu_a > bus.alu_b};
            3'b110: alu_res = {bus.alu_a, 1'b0};
            default: alu_res = {bus.alu_b, 1'b0};
        endcase
        bus.alu_out    = alu_res[7:0];
        bus.alu_cout   = alu_res[8];
        bus.alu_c_flag = (bus.alu_a > bus.alu_b);
        bus.alu_zero   = (alu_res[7:0] == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one command, optionally stall the response for 'hold' cycles
    task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                          input int hold,
                          output logic [7:0] data, output logic [2:0] flags, output int lat,
                          output logic [7:0] a_seen, output logic [7:0] b_seen);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        a_seen = bus.alu_a;
        b_seen = bus.alu_b;
        lat = 0;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        data  = bus.rsp_data;
        flags = bus.rsp_flags;
        for (int i = 0; i < hold; i++) begin
            // Stray command while RESP must be ignored
            bus.cmd_valid = 1'b1;
            bus.cmd_load  = 1'b1;
            bus.cmd_rd    = 2'd3;
            bus.cmd_imm   = 8'hAA;
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data",  32'(bus.rsp_data),  32'(data));
            check("hold_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold_busy",  32'(bus.busy),      32'd1);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        if (hold > 0) begin
            check("release_ready", 32'(bus.cmd_ready), 32'd1);
            check("release_busy",  32'(bus.busy),      32'd0);
            check("release_valid", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    // Issue a command and check its response value, flags and latency
    task automatic op_chk(input string tag, input logic ld, input logic [2:0] op,
                          input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [7:0] imm, input logic [7:0] exp_data,
                          input logic [2:0] exp_flags, input int exp_lat);
        logic [7:0] d, a, b;
        logic [2:0] f;
        int         l;
        do_cmd(ld, op, rd, rs1, rs2, imm, 0, d, f, l, a, b);
        check({tag, "_data"},  32'(d), 32'(exp_data));
        check({tag, "_flags"}, 32'(f), 32'(exp_flags));
        check({tag, "_lat"},   32'(l), 32'(exp_lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, a, b;
        logic [2:0] f;
        int         l;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_rd    = 2'd0;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd0;
        bus.cmd_imm   = 8'd0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check("rst_alu_op",    32'(bus.alu_op),    32'd0);
        for (int r = 0; r < 4; r++) begin
            op_chk("rst_reg", 1'b0, 3'b011, 2'(r), 2'(r), 2'(r), 8'h00, 8'h00, 3'b001, 1);
        end

        // Load and add with carry
        op_chk("ld_r0", 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 3'b000, 0);
        op_chk("ld_r1", 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 3'b000, 0);
        do_cmd(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 0, d, f, l, a, b);
        check("add_alu_a", 32'(a), 32'hF0);
        check("add_alu_b", 32'(b), 32'h20);
        check("add_data",  32'(d), 32'h10);
        check("add_flags", 32'(f), 32'(3'b110));
        check("add_lat",   32'(l), 32'd1);
        check("add_op_hold", 32'(bus.alu_op), 32'd0);
        op_chk("rd_r2", 1'b0, 3'b011, 2'd0, 2'd2, 2'd2, 8'h00, 8'h10, 3'b000, 1);

        // Subtract to zero: no-borrow carry set
        op_chk("sub", 1'b0, 3'b001, 2'd3, 2'd1, 2'd1, 8'h00, 8'h00, 3'b101, 1);
        op_chk("rd_r3", 1'b0, 3'b011, 2'd1, 2'd3, 2'd3, 8'h00, 8'h00, 3'b001, 1);
        op_chk("ld_zero", 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 3'b001, 0);

        // Response backpressure on an xor
        op_chk("ld_0f", 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h0F, 8'h0F, 3'b000, 0);
        op_chk("ld_ff", 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 3'b000, 0);
        do_cmd(1'b0, 3'b100, 2'd2, 2'd0, 2'd1, 8'h00, 5, d, f, l, a, b);
        check("xor_data",  32'(d), 32'hF0);
        check("xor_flags", 32'(f), 32'(3'b000));
        op_chk("stray_r3", 1'b0, 3'b011, 2'd3, 2'd3, 2'd3, 8'h00, 8'h00, 3'b001, 1);

        // Overwrite-self shift
        op_chk("ld_81", 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h81, 8'h81, 3'b000, 0);
        op_chk("shl_self", 1'b0, 3'b110, 2'd0, 2'd0, 2'd0, 8'h00, 8'h02, 3'b100, 1);
        op_chk("or_r0", 1'b0, 3'b011, 2'd1, 2'd0, 2'd0, 8'h00, 8'h02, 3'b000, 1);
        op_chk("gt", 1'b0, 3'b101, 2'd3, 2'd0, 2'd2, 8'h00, 8'h00, 3'b001, 1);

        // Reset during EXEC of an add targeting R2
        op_chk("ld_50", 1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h50, 8'h50, 3'b000, 0);
        op_chk("ld_05", 1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 3'b000, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_rd    = 2'd2;
        bus.cmd_rs1   = 2'd0;
        bus.cmd_rs2   = 2'd1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_alu_out", 32'(bus.alu_out), 32'h55);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        check("mrst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mrst_ready", 32'(bus.cmd_ready), 32'd1);
        check("mrst_busy",  32'(bus.busy),      32'd0);
        check("mrst_alu_op", 32'(bus.alu_op),   32'd0);
        check("mrst_alu_a", 32'(bus.alu_a),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;
        op_chk("mrst_r2", 1'b0, 3'b011, 2'd3, 2'd2, 2'd2, 8'h00, 8'h00, 3'b001, 1);
        op_chk("mrst_r0", 1'b0, 3'b011, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 3'b001, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side master for the 8-bit ALU. Accepts register-addressed commands over a valid/ready channel and holds a 4-entry operand register file.
- For each command it drives the ALU's A/B/op inputs for one cycle, captures the result and flags, and writes the result back to the register file.
- Returns each result on a valid/ready response channel. It sits between the instruction source and the ALU, and the ALU remains purely combinational.

Parameters:
- WIDTH, 8, data width of operands, results and register entries.
- NREG, 4, number of register-file entries. Register addresses are 2 bits. Only 4 is supported.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command. High only in IDLE.
- cmd_load  input  1  1 = load cmd_imm into rd with no ALU use. 0 = ALU operation.
- cmd_op  input  3  ALU opcode, passed through unchanged. 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 gt, 110 shl A, 111 shl B.
- cmd_rd  input  2  destination register.
- cmd_rs1  input  2  source register driven onto ALU A.
- cmd_rs2  input  2  source register driven onto ALU B.
- cmd_imm  input  WIDTH  immediate value for loads.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  3  to ALU op.
- alu_out  input  WIDTH  from ALU out.
- alu_cout  input  1  from ALU carry-out.
- alu_c_flag  input  1  from ALU comparison flag (A>B).
- alu_zero  input  1  from ALU zero flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  value written to rd.
- rsp_flags  output  3  {cout, c_flag, zero} for this command.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All registers R0..R3 = 0.
  - alu_a, alu_b = 0; alu_op = 000.
  - rsp_valid = 0, rsp_data = 0, rsp_flags = 000, busy = 0.
  - Reset takes priority over every other event. A command in flight is abandoned with no writeback and no response.
- States: IDLE, EXEC, RESP. The state encoding is free.
- IDLE:
  - cmd_ready=1. A handshake occurs when cmd_valid & cmd_ready at an edge.
  - Load command: R[rd] <= cmd_imm; rsp_data <= cmd_imm; rsp_flags <= {0, 0, cmd_imm==0}; next state RESP.
  - ALU command:
    - alu_a <= R[rs1] and alu_b <= R[rs2], read from register contents before that edge.
    - alu_op <= cmd_op; latch rd; next state EXEC.
- EXEC (exactly one cycle):
  - Registered operands are stable on the ALU for the whole cycle.
  - At the end-of-cycle edge:
    - R[rd] <= alu_out.
    - rsp_data <= alu_out.
    - rsp_flags <= {alu_cout, alu_c_flag, alu_zero}.
  - Next state RESP.
- RESP:
  - rsp_valid=1, with rsp_data and rsp_flags held stable until rsp_ready=1 at an edge; then IDLE.
  - rsp_valid must not drop without a handshake.
- Latency, counting the acceptance edge as edge 0:
  - ALU op: rsp_valid is high after edge 1.
  - Load: rsp_valid is high after edge 0.
  - Back-to-back throughput with rsp_ready tied high: one ALU op per 3 cycles, one load per 2 cycles.
- No overlap: the next command is accepted only in IDLE. cmd_ready=0 in EXEC and RESP, so a later command always reads any rd written earlier.
- rd equal to rs1 or rs2 is legal. Operands are captured before writeback.
- alu_a, alu_b and alu_op hold their last values outside EXEC. They change only at an ALU-command acceptance edge.
- Arithmetic is performed entirely by the ALU. The sequencer does no width extension and passes cout through unmodified, including the subtract carry (1 = no borrow).
- cmd_* inputs are ignored outside the IDLE handshake.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> cmd_ready=1, busy=0, rsp_valid=0, all registers read back 0x00 via "or Rn,Rn" commands, rsp_flags=001.
- Load and add: load R0=0xF0, load R1=0x20, then op=000 rd=2 rs1=0 rs2=1, with a reference ALU attached:
  - alu_a=0xF0 and alu_b=0x20 during EXEC.
  - rsp_data=0x10, rsp_flags=110, rsp_valid one edge after EXEC.
- Subtract to zero: R1=0x20, op=001 rd=3 rs1=1 rs2=1 -> rsp_data=0x00, rsp_flags=101, R3=0x00.
- Response backpressure: hold rsp_ready=0 for 5 cycles after an xor of 0x0F^0xFF:
  - rsp_valid stays 1, rsp_data=0xF0 stable, cmd_ready=0 and busy=1 throughout.
  - Raise rsp_ready -> IDLE on the next edge.
- Overwrite-self: R0=0x81, op=110 rd=0 rs1=0 rs2=0 -> rsp_data=0x02, R0 becomes 0x02. A following "or R1=R0|R0" returns 0x02.
- Reset mid-operation: assert rst_n=0 during EXEC of an add targeting R2=0x55 -> no response, state IDLE, R2=0x00, alu_op=000.
